synaptic_arb: RTL and testbench

- Frame-level round-robin arbiter that shares one synaptic pipeline (index encoder + accumulator) between P spike-word producers.
- Each producer delivers frames of N/32 32-bit sparse spike words.
- The arbiter locks the winning source for a whole frame and forwards its words with source tag and word index. It skips all-zero words, then waits for the pipeline to drain before granting the next frame, so accumulations from different sources never mix.

---
 rtl/snn_pkg.sv | 21 ++
 rtl/synaptic_arb_rr_pick.sv | 33 +++
 rtl/synaptic_arb.sv | 133 +++++++++++++
 tb/tb_synaptic_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
// Contents: arbiter state encoding, spike word width, and an index-width helper.
package snn_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // Width needed to index n items. A single item still gets a 1-bit index,
  // so that ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/synaptic_arb_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping modulo P.
// Latency: purely combinational.
// Backpressure: none; it only selects and never accepts anything itself.
// Ports: req (request vector), ptr (highest-priority index), onehot/idx (winner; all zero if no request).
module rr_pick #(
  parameter int P  = 2,
  parameter int SW = 1
) (
  input  logic [P-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [P-1:0]  onehot,
  output logic [SW-1:0] idx
);

  logic found;
  int   cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < P; k++) begin
      cand = (int'(ptr) + k) % P;
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = SW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synaptic_arb.sv
// Frame-level round-robin arbiter sharing one synaptic pipeline among P spike-word producers.
// Latency: one arbitration cycle per frame, then words pass through with zero latency.
// Backpressure: the granted source sees syn_ready for nonzero words, and zero words are consumed locally.
// Ports: req_bits/req_valid/req_ready (producers); syn_bits/valid/ready/src/widx/last (pipeline);
//        syn_idle (pipeline drained); frame_done (per-source completion pulse); busy (XFER or DRAIN).
module synaptic_arb
  import snn_pkg::*;
#(
  parameter  int P     = 2,
  parameter  int N     = 128,
  localparam int WORDS = N / WORD_W,
  localparam int SW    = idx_width(P),
  localparam int IW    = idx_width(WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P*WORD_W-1:0] req_bits,
  input  logic [P-1:0]        req_valid,
  output logic [P-1:0]        req_ready,
  output logic [WORD_W-1:0]   syn_bits,
  output logic                syn_valid,
  input  logic                syn_ready,
  output logic [SW-1:0]       syn_src,
  output logic [IW-1:0]       syn_widx,
  output logic                syn_last,
  input  logic                syn_idle,
  output logic [P-1:0]        frame_done,
  output logic                busy
);

  arb_state_t state, state_nxt;

  logic [SW-1:0]     rr_ptr;
  logic [SW-1:0]     grant;
  logic [IW-1:0]     word_cnt;
  logic              drain_first;  // high only on the DRAIN entry cycle
  logic [P-1:0]      pick_oh;
  logic [SW-1:0]     pick_idx;
  logic              pick_any;
  logic [WORD_W-1:0] cur_bits;
  logic              cur_vld;
  logic              cur_zero;
  logic              cur_last;
  logic              grant_rdy;
  logic              accept;

  rr_pick #(.P(P), .SW(SW)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign pick_any = |pick_oh;
  assign cur_bits = req_bits[WORD_W*int'(grant) +: WORD_W];
  assign cur_vld  = req_valid[grant];
  assign cur_zero = (cur_bits == '0);
  assign cur_last = (word_cnt == IW'(WORDS - 1));

  // Zero words never reach the pipeline, so they do not wait on syn_ready.
  assign grant_rdy = cur_zero | syn_ready;

  assign syn_bits = cur_bits;
  assign syn_src  = grant;
  assign syn_widx = word_cnt;
  assign syn_last = cur_last;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    syn_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        req_ready[grant] = grant_rdy;
        syn_valid        = cur_vld & ~cur_zero;
        accept           = cur_vld & grant_rdy;
        if (accept && cur_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The entry cycle is skipped: the encoder register has not yet
        // absorbed the final word, so syn_idle may still read stale-high.
        if (!drain_first && syn_idle) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      word_cnt    <= '0;
      drain_first <= 1'b0;
      frame_done  <= '0;
    end else begin
      state       <= state_nxt;
      frame_done  <= '0;
      drain_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            word_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (accept) begin
            if (cur_last) begin
              word_cnt    <= '0;
              drain_first <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!drain_first && syn_idle) begin
            frame_done <= {{(P-1){1'b0}}, 1'b1} << grant;
            rr_ptr     <= (grant == SW'(P - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_arb.sv
// Directed bench for synaptic_arb (P=2, N=128) with a scoreboard of forwarded words.
// Producers drive on the falling edge; the monitor samples one time unit before the rising edge.
module tb_synaptic_arb;

  typedef struct packed {
    logic [0:0]  src;
    logic [1:0]  widx;
    logic [31:0] bits;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;
  wire  [63:0] req_bits;
  wire  [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] syn_bits;
  logic        syn_valid;
  logic        syn_ready;
  logic [0:0]  syn_src;
  logic [1:0]  syn_widx;
  logic        syn_last;
  logic        syn_idle;
  logic [1:0]  frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] src_q [2][$];
  exp_t        exp_q[$];
  logic [1:0]  done_q[$];
  int          done_cyc[$];
  int          vcount    = 0;
  int          last_seen = 0;
  int          w1_seen   = 0;

  synaptic_arb #(.P(2), .N(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_bits   (req_bits),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .syn_bits   (syn_bits),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_src    (syn_src),
    .syn_widx   (syn_widx),
    .syn_last   (syn_last),
    .syn_idle   (syn_idle),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Each producer presents the head of its queue and pops it once accepted.
  for (genvar g = 0; g < 2; g++) begin : prod
    logic        v;
    logic [31:0] b;
    logic        acc;
    assign req_valid[g]          = v;
    assign req_bits[32*g +: 32]  = b;
    initial begin
      v = 1'b0; b = '0; acc = 1'b0;
      forever begin
        @(negedge clk);
        if (acc && rst_n && src_q[g].size() > 0) void'(src_q[g].pop_front());
        if (src_q[g].size() > 0) begin v = 1'b1; b = src_q[g][0]; end
        else begin v = 1'b0; b = '0; end
        #4 acc = v & req_ready[g];
      end
    end
  end

  // Monitor: scoreboard compare on each pipeline transfer, plus per-cycle rules.
  initial begin
    exp_t obs;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        check("ready_excl", 64'(req_ready & ~(2'b01 << syn_src)), 64'd0);
        if (syn_valid) begin
          vcount++;
          check("ready_mirror", 64'(req_ready[syn_src]), 64'(syn_ready));
        end
        if (syn_valid && syn_ready) begin
          obs = '{src: syn_src, widx: syn_widx, bits: syn_bits, last: syn_last};
          check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("word", 64'(obs), 64'(exp_q.pop_front()));
          if (syn_last) last_seen++;
          if (syn_widx == 2'd1) w1_seen++;
        end
        if (frame_done != 2'b00) begin
          done_q.push_back(frame_done);
          done_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [31:0] wv(input int s, input int f, input int w);
    return 32'(((s + 1) << 24) | (f << 8) | (w + 1));
  endfunction

  task automatic load(input int s, input logic [31:0] w[4]);
    for (int i = 0; i < 4; i++) begin
      src_q[s].push_back(w[i]);
      if (w[i] != 32'd0)
        exp_q.push_back('{src: 1'(s), widx: 2'(i), bits: w[i], last: (i == 3)});
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_busy(output int c);
    int n = 0;
    while (!busy && n < 100) begin step(); n++; end
    check("busy_rise", 64'(busy), 64'd1);
    c = cyc;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] mask, output int c);
    int n = 0;
    c = -1;
    while (done_q.size() == 0 && n < 200) begin step(); n++; end
    check({tag, "_seen"}, 64'(done_q.size() > 0), 64'd1);
    if (done_q.size() > 0) begin
      check(tag, 64'(done_q.pop_front()), 64'(mask));
      c = done_cyc.pop_front();
    end
  endtask

  initial begin
    logic [31:0] fr[4];
    int cb, cd, cr, v0, d0, n;

    rst_n = 1'b0; syn_ready = 1'b1; syn_idle = 1'b1;
    repeat (3) step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_syn_valid", 64'(syn_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    step();

    // Single source with a zero word inside the frame.
    fr = '{32'h1, 32'h0, 32'h8000_0000, 32'hF};
    load(0, fr);
    wait_busy(cb);
    wait_done("single_done", 2'b01, cd);
    check("single_timing", 64'(cd - cb), 64'd6);
    check("single_sb_empty", 64'(exp_q.size()), 64'd0);

    // All-zero frame from source 1: nothing forwarded, 1+4+2 cycles.
    v0 = vcount;
    fr = '{32'h0, 32'h0, 32'h0, 32'h0};
    load(1, fr);
    wait_busy(cb);
    wait_done("zero_done", 2'b10, cd);
    check("zero_timing", 64'(cd - cb), 64'd6);
    check("zero_no_valid", 64'(vcount - v0), 64'd0);

    // Contention: two frames per source, grants must alternate 0,1,0,1.
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 2; s++) begin
        for (int w = 0; w < 4; w++) fr[w] = wv(s, f, w);
        load(s, fr);
      end
    wait_done("cont_g0", 2'b01, cd);
    wait_done("cont_g1", 2'b10, cd);
    wait_done("cont_g2", 2'b01, cd);
    wait_done("cont_g3", 2'b10, cd);
    check("cont_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: syn_ready alternates every cycle during a frame.
    for (int w = 0; w < 4; w++) fr[w] = wv(0, 2, w);
    load(0, fr);
    n = 0;
    while (done_q.size() == 0 && n < 200) begin
      step();
      syn_ready = ~syn_ready;
      n++;
    end
    syn_ready = 1'b1;
    wait_done("bp_done", 2'b01, cd);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Drain hold: pipeline stays busy for 10 cycles after the last word.
    syn_idle = 1'b0;
    d0 = last_seen;
    for (int w = 0; w < 4; w++) fr[w] = wv(1, 3, w);
    load(1, fr);
    n = 0;
    while (last_seen == d0 && n < 100) begin step(); n++; end
    check("hold_last_seen", 64'(last_seen - d0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_ready", 64'(req_ready), 64'd0);
      check("hold_no_done", 64'(done_q.size()), 64'd0);
    end
    syn_idle = 1'b1;
    cr = cyc;
    wait_done("hold_done", 2'b10, cd);
    check("hold_timing", 64'(cd - cr), 64'd1);

    // Reset mid-frame, right after widx 1 has been accepted.
    d0 = w1_seen;
    for (int w = 0; w < 4; w++) fr[w] = wv(0, 4, w);
    load(0, fr);
    n = 0;
    while (w1_seen == d0 && n < 100) begin step(); n++; end
    check("rst_mid_w1", 64'(w1_seen - d0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(syn_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    check("rst_mid_done", 64'(frame_done), 64'd0);
    src_q[0].delete();
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_no_pulse", 64'(done_q.size()), 64'd0);
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 4; w++) fr[w] = wv(s, 5, w);
      load(s, fr);
    end
    wait_done("post_rst_g0", 2'b01, cd);
    wait_done("post_rst_g1", 2'b10, cd);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check("final_no_extra", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
